// File: rtl/logic_unit_bist.sv
// rtl/logic_unit_bist.sv - BIST driver/checker sweeping all 16 vectors of the 2-input, 4-function logic unit
module logic_unit_bist #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        lu_a,
  output logic        lu_b,
  output logic [1:0]  lu_select,
  input  logic        lu_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_count,
  output logic [15:0] fail_map,
  output logic [3:0]  first_fail_idx
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic       expected;
  logic       mismatch;
  logic       last_vec;

  // Drive comes straight from the registered index, never from state decode.
  assign lu_select = idx[3:2];
  assign lu_a      = idx[1];
  assign lu_b      = idx[0];
  assign last_vec  = (idx == 4'd15);

  always_comb begin
    expected = 1'b0;
    case (idx[3:2])
      2'b00: expected = idx[1] ^ idx[0];
      2'b01: expected = ~(idx[1] ^ idx[0]);
      2'b10: expected = idx[1] | idx[0];
      2'b11: expected = ~(idx[1] | idx[0]);
      default: expected = 1'b0;
    endcase
  end

  assign mismatch = (state == CHECK) && (lu_out != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (cnt == 4'd0) state_nxt = CHECK;
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = last_vec ? DONE : SETTLE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx            <= 4'd0;
      cnt            <= 4'd0;
      pass           <= 1'b0;
      fail_count     <= 5'd0;
      fail_map       <= 16'h0000;
      first_fail_idx <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx            <= 4'd0;
            cnt            <= RELOAD;
            pass           <= 1'b0;
            fail_count     <= 5'd0;
            fail_map       <= 16'h0000;
            first_fail_idx <= 4'd0;
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        CHECK: begin
          if (mismatch) begin
            fail_map[idx] <= 1'b1;
            fail_count    <= fail_count + 5'd1;
            if (fail_count == 5'd0) first_fail_idx <= idx;
          end
          // Resolve pass with the final vector folded in so it is valid alongside done.
          if (last_vec) begin
            pass <= (fail_count == 5'd0) && !mismatch;
          end else begin
            idx <= idx + 4'd1;
            cnt <= RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_bist.sv
// tb/tb_logic_unit_bist.sv - randomized self-checking bench for logic_unit_bist (SETTLE_CYCLES 1 and 0)
module tb_logic_unit_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   mode = 0;
  logic [15:0] rmask = 16'h0000;

  logic a0, b0, out0, busy0, done0, pass0;
  logic [1:0] sel0;
  logic [4:0] fc0;
  logic [15:0] fm0;
  logic [3:0] ff0;
  logic a1, b1, out1, busy1, done1, pass1;
  logic [1:0] sel1;
  logic [4:0] fc1;
  logic [15:0] fm1;
  logic [3:0] ff1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic golden(input logic [1:0] s, input logic a, input logic b);
    case (s)
      2'b00: return a ^ b;
      2'b01: return ~(a ^ b);
      2'b10: return a | b;
      default: return ~(a | b);
    endcase
  endfunction

  // 0 good unit, 1 stuck-0, 2 stuck-1, 3 XOR/XNOR swapped, 4 good unit with random flip mask
  function automatic logic unit_fn(input int m, input logic [15:0] msk,
                                   input logic [1:0] s, input logic a, input logic b);
    logic [3:0] v;
    v = {s, a, b};
    case (m)
      1: return 1'b0;
      2: return 1'b1;
      3: return (s == 2'b00) ? ~(a ^ b) : (s == 2'b01) ? (a ^ b) : golden(s, a, b);
      4: return golden(s, a, b) ^ msk[v];
      default: return golden(s, a, b);
    endcase
  endfunction

  function automatic logic [15:0] exp_map(input int m, input logic [15:0] msk);
    logic [15:0] r;
    logic [3:0] v;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      r[i] = unit_fn(m, msk, v[3:2], v[1], v[0]) != golden(v[3:2], v[1], v[0]);
    end
    return r;
  endfunction

  assign out0 = unit_fn(mode, rmask, sel0, a0, b0);
  assign out1 = unit_fn(mode, rmask, sel1, a1, b1);

  logic_unit_bist #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .lu_a(a0), .lu_b(b0), .lu_select(sel0), .lu_out(out0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fc0), .fail_map(fm0), .first_fail_idx(ff0)
  );

  logic_unit_bist #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .lu_a(a1), .lu_b(b1), .lu_select(sel1), .lu_out(out1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .fail_map(fm1), .first_fail_idx(ff1)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Model: t = cycle number since the accepted start (-1 when idle); fin = a sweep has completed.
  int          t[2]    = '{-1, -1};
  bit          fin[2]  = '{1'b0, 1'b0};
  logic [15:0] snap[2] = '{16'h0000, 16'h0000};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        t[i] = -1;
        fin[i] = 1'b0;
        snap[i] = 16'h0000;
      end else if (t[i] == 16 * ((i == 0 ? 1 : 0) + 2) + 1) begin
        t[i] = -1;
        fin[i] = 1'b1;
      end else if (t[i] >= 1) begin
        t[i]++;
      end else if (start) begin
        t[i] = 1;
        fin[i] = 1'b0;
        snap[i] = exp_map(mode, rmask);
      end
    end
  end

  task automatic cmp(input int i, input logic [3:0] lu, input logic bz, input logic dn,
                     input logic ps, input logic [4:0] fc, input logic [15:0] fm,
                     input logic [3:0] ff);
    int s, d, k, eli, ef;
    logic eb, ed, ep;
    logic [15:0] em;
    string p;
    s = (i == 0) ? 1 : 0;
    d = 16 * (s + 2) + 1;
    eb = 1'b0; ed = 1'b0; ep = 1'b0;
    if (t[i] < 0) begin
      k = fin[i] ? 16 : 0;
      eli = fin[i] ? 15 : 0;
      ep = fin[i] && (snap[i] == 16'h0000);
    end else if (t[i] < d) begin
      k = (t[i] - 1) / (s + 2);
      eli = k;
      eb = 1'b1;
    end else begin
      k = 16;
      eli = 15;
      ed = 1'b1;
      ep = (snap[i] == 16'h0000);
    end
    em = 16'h0000;
    for (int j = 0; j < k; j++) em[j] = snap[i][j];
    ef = 0;
    for (int j = 15; j >= 0; j--) if (em[j]) ef = j;
    p = $sformatf("s%0d_t%0d", s, t[i]);
    chk({p, "_lu_vec"}, lu, eli);
    chk({p, "_busy"}, bz, eb);
    chk({p, "_done"}, dn, ed);
    chk({p, "_pass"}, ps, ep);
    chk({p, "_fail_count"}, fc, $countones(em));
    chk({p, "_fail_map"}, fm, em);
    chk({p, "_first_fail"}, ff, ef);
  endtask

  always @(negedge clk) begin
    cmp(0, {sel0, a0, b0}, busy0, done0, pass0, fc0, fm0, ff0);
    cmp(1, {sel1, a1, b1}, busy1, done1, pass1, fc1, fm1, ff1);
  end

  task automatic run_sweep(input int m, input logic [15:0] msk, input int extra,
                           output int da, output int db);
    mode = m;
    rmask = msk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    da = -1;
    db = -1;
    for (int c = 1; c <= 70; c++) begin
      if (done0 && da < 0) da = c;
      if (done1 && db < 0) db = c;
      if (da > 0 && c > da) break;
      start = (c == extra);
      @(negedge clk);
    end
    start = 1'b0;
    chk("sweep_timeout_s1", int'(da > 0), 1);
    chk("sweep_timeout_s0", int'(db > 0), 1);
  endtask

  int da, db;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_lu", {sel0, a0, b0}, 0);
    chk("rst_fail_map", fm0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    chk("model_pin_stuck0", exp_map(1, 16'h0), 16'h1E96);
    chk("model_pin_stuck1", exp_map(2, 16'h0), 16'hE169);
    chk("model_pin_swap", exp_map(3, 16'h0), 16'h00FF);

    run_sweep(0, 16'h0, 0, da, db);
    chk("good_done_cycle_s1", da, 49);
    chk("good_done_cycle_s0", db, 33);
    chk("good_pass", pass0, 1);
    chk("good_fail_map", fm0, 16'h0000);
    chk("good_pass_s0", pass1, 1);

    run_sweep(1, 16'h0, 0, da, db);
    chk("stuck0_pass", pass0, 0);
    chk("stuck0_count", fc0, 8);
    chk("stuck0_map", fm0, 16'h1E96);
    chk("stuck0_first", ff0, 1);

    run_sweep(2, 16'h0, 0, da, db);
    chk("stuck1_count", fc0, 8);
    chk("stuck1_map", fm0, 16'hE169);
    chk("stuck1_first", ff0, 0);

    run_sweep(3, 16'h0, 0, da, db);
    chk("swap_map", fm0, 16'h00FF);
    chk("swap_count", fc0, 8);
    chk("swap_first", ff0, 0);

    // Mid-sweep restart attempt, then reset during vector 7.
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c < 22; c++) begin
      start = (c == 5);
      @(negedge clk);
    end
    start = 1'b0;
    chk("abort_at_vec7", {sel0, a0, b0}, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_lu", {sel0, a0, b0}, 0);
    chk("abort_fail_count", fc0, 0);
    chk("abort_pass", pass0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(0, 16'h0, 0, da, db);
    chk("after_abort_done_cycle", da, 49);
    chk("after_abort_pass", pass0, 1);

    for (int n = 0; n < 8; n++) begin
      run_sweep(4, 16'($urandom), (n % 3 == 0) ? 33 : int'($urandom_range(2, 30)), da, db);
      chk("rand_done_cycle_s1", da, 49);
      chk("rand_done_cycle_s0", db, 33);
    end

    run_sweep(4, 16'hFFFF, 0, da, db);
    chk("all_fail_count", fc0, 16);
    chk("all_fail_map", fm0, 16'hFFFF);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
